// File: rtl/mood_pkg.sv
// Shared definitions for the RGB mood sequencer: mode encoding, level type
// and the colour-wheel lookup used by the RAINBOW pattern.
package mood_pkg;

    // Mode FSM state encoding (also the externally visible mode value)
    localparam logic [1:0] MODE_MANUAL  = 2'd0;
    localparam logic [1:0] MODE_BREATHE = 2'd1;
    localparam logic [1:0] MODE_RAINBOW = 2'd2;
    localparam logic [1:0] MODE_STROBE  = 2'd3;

    localparam int LVL_MAX    = 7;
    localparam int HUE_PHASES = 6;

    typedef logic [2:0] level_t;
    typedef logic [2:0] hue_t;

    typedef struct packed {
        level_t r;
        level_t g;
        level_t b;
    } rgb_t;

    // Modes advance cyclically; the 2-bit wrap takes STROBE back to MANUAL.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return m + 2'd1;
    endfunction

    // Colour wheel: six phases, each ramping one channel while the other two
    // are pinned at full or zero.
    function automatic rgb_t rainbow_rgb(input hue_t h, input level_t k);
        rgb_t   c;
        level_t full;
        level_t inv;
        full = level_t'(LVL_MAX);
        inv  = full - k;
        case (h)
            3'd0:    c = '{r: full,  g: k,     b: 3'd0};
            3'd1:    c = '{r: inv,   g: full,  b: 3'd0};
            3'd2:    c = '{r: 3'd0,  g: full,  b: k};
            3'd3:    c = '{r: 3'd0,  g: inv,   b: full};
            3'd4:    c = '{r: k,     g: 3'd0,  b: full};
            3'd5:    c = '{r: full,  g: 3'd0,  b: inv};
            default: c = '{r: 3'd0,  g: 3'd0,  b: 3'd0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debouncer and
// a one-cycle press pulse on the debounced rising edge.
module pb_debounce
#(
    parameter int DB_CYC = 500_000
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          db_prev_q, db_prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: the debounced level flips only after the synchronized input
    // has disagreed with it for DB_CYC cycles in a row; any agreement restarts.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DB_CYC - 1)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;
    end

    // State registers; all levels clear so a button held through reset
    // release is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mood_sequencer.sv
// Automatic colour-pattern controller driving the RGB channel levels:
// mode FSM, step-rate register, tick prescaler and pattern datapath.
module mood_sequencer
    import mood_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int DB_CYC   = 500_000
)
(
    input  logic       tp_clk,
    input  logic       tp_rst,
    input  logic       pb_mode,
    input  logic       pb_faster,
    input  logic       pb_slower,
    input  logic [2:0] man_r,
    input  logic [2:0] man_g,
    input  logic [2:0] man_b,
    output logic [2:0] sel_r,
    output logic [2:0] sel_g,
    output logic [2:0] sel_b,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic          mode_press;
    logic          faster_press;
    logic          slower_press;

    logic [1:0]    mode_q, mode_d;
    logic [1:0]    speed_q, speed_d;
    logic [PW-1:0] presc_q, presc_d;
    level_t        lvl_q, lvl_d;
    logic          dir_down_q, dir_down_d;
    hue_t          hue_q, hue_d;
    level_t        k_q, k_d;
    logic          strobe_on_q, strobe_on_d;
    level_t        sel_r_q, sel_r_d;
    level_t        sel_g_q, sel_g_d;
    level_t        sel_b_q, sel_b_d;

    logic [PW-1:0] period_m1;
    logic          tick;
    rgb_t          wheel;

    pb_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
        .clk   (tp_clk),
        .rst_n (tp_rst),
        .raw   (pb_mode),
        .press (mode_press)
    );

    pb_debounce #(.DB_CYC(DB_CYC)) u_db_faster (
        .clk   (tp_clk),
        .rst_n (tp_rst),
        .raw   (pb_faster),
        .press (faster_press)
    );

    pb_debounce #(.DB_CYC(DB_CYC)) u_db_slower (
        .clk   (tp_clk),
        .rst_n (tp_rst),
        .raw   (pb_slower),
        .press (slower_press)
    );

    // Step period shrinks by powers of two with speed; ">=" catches a count
    // left above the new terminal value after speeding up.
    always_comb begin
        period_m1 = PW'((TICK_DIV >> speed_q) - 1);
        tick      = (mode_q != MODE_MANUAL) && (presc_q >= period_m1);
    end

    // Next-state for speed, mode, prescaler and pattern state; a mode press
    // wins over a coincident tick and restarts every pattern from scratch.
    always_comb begin
        speed_d     = speed_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        lvl_d       = lvl_q;
        dir_down_d  = dir_down_q;
        hue_d       = hue_q;
        k_d         = k_q;
        strobe_on_d = strobe_on_q;

        if (faster_press && !slower_press && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end else if (slower_press && !faster_press && speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
        end

        if (mode_press) begin
            mode_d      = next_mode(mode_q);
            presc_d     = '0;
            lvl_d       = '0;
            dir_down_d  = 1'b0;
            hue_d       = '0;
            k_d         = '0;
            strobe_on_d = 1'b1;
        end else if (mode_q == MODE_MANUAL) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            case (mode_q)
                MODE_BREATHE: begin
                    if (!dir_down_q && lvl_q == level_t'(LVL_MAX)) begin
                        lvl_d      = level_t'(LVL_MAX - 1);
                        dir_down_d = 1'b1;
                    end else if (dir_down_q && lvl_q == '0) begin
                        lvl_d      = level_t'(1);
                        dir_down_d = 1'b0;
                    end else if (dir_down_q) begin
                        lvl_d = lvl_q - level_t'(1);
                    end else begin
                        lvl_d = lvl_q + level_t'(1);
                    end
                end
                MODE_RAINBOW: begin
                    if (k_q == level_t'(LVL_MAX)) begin
                        k_d   = '0;
                        hue_d = (hue_q == hue_t'(HUE_PHASES - 1)) ? '0 : hue_q + hue_t'(1);
                    end else begin
                        k_d = k_q + level_t'(1);
                    end
                end
                MODE_STROBE: begin
                    strobe_on_d = ~strobe_on_q;
                end
                default: begin
                end
            endcase
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Channel levels are derived from the next pattern state so they move on
    // the same edge as the pattern itself.
    always_comb begin
        wheel   = rainbow_rgb(hue_d, k_d);
        sel_r_d = man_r;
        sel_g_d = man_g;
        sel_b_d = man_b;
        case (mode_d)
            MODE_BREATHE: begin
                sel_r_d = lvl_d;
                sel_g_d = lvl_d;
                sel_b_d = lvl_d;
            end
            MODE_RAINBOW: begin
                sel_r_d = wheel.r;
                sel_g_d = wheel.g;
                sel_b_d = wheel.b;
            end
            MODE_STROBE: begin
                if (!strobe_on_d) begin
                    sel_r_d = '0;
                    sel_g_d = '0;
                    sel_b_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset abandons any step in progress.
    always_ff @(posedge tp_clk or negedge tp_rst) begin
        if (!tp_rst) begin
            mode_q      <= MODE_MANUAL;
            speed_q     <= 2'd0;
            presc_q     <= '0;
            lvl_q       <= '0;
            dir_down_q  <= 1'b0;
            hue_q       <= '0;
            k_q         <= '0;
            strobe_on_q <= 1'b0;
            sel_r_q     <= '0;
            sel_g_q     <= '0;
            sel_b_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            presc_q     <= presc_d;
            lvl_q       <= lvl_d;
            dir_down_q  <= dir_down_d;
            hue_q       <= hue_d;
            k_q         <= k_d;
            strobe_on_q <= strobe_on_d;
            sel_r_q     <= sel_r_d;
            sel_g_q     <= sel_g_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign sel_r     = sel_r_q;
    assign sel_g     = sel_g_q;
    assign sel_b     = sel_b_q;
    assign mode      = mode_q;
    assign step_tick = tick;

endmodule
